// File: rtl/uart_fifo_ctrl.sv
// Bus-side controller for one uart core: register file, TX/RX byte FIFOs,
// a two-state TX write handshake and RX read capture with a stale-valid guard.
module uart_fifo_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic        uart_wr_o,
  output logic [7:0]  uart_tx_data_o,
  input  logic        uart_busy_i,
  output logic        uart_rd_o,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_valid_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, GUARD} tx_state_e;

  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  tx_state_e     state_q, state_d;
  logic          rx_guard_q, rx_guard_d;
  logic          post_rst_q, post_rst_d;
  logic          tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic          bus_wr, bus_rd, pulse_ok;
  logic          tx_push, tx_pop, rx_push, rx_pop, rx_take;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [31:0]   status;
  logic          unused_wdata;

  assign unused_wdata = ^{wdata_i[31:8], wdata_i[3:2]};

  always_comb begin
    tx_empty = (tx_cnt_q == '0);
    tx_full  = (tx_cnt_q == FULL);
    rx_empty = (rx_cnt_q == '0);
    rx_full  = (rx_cnt_q == FULL);
    bus_wr   = sel_i & we_i;
    bus_rd   = sel_i & ~we_i;
    // No UART handshake may start in the reset cycle or the one after it.
    pulse_ok = ~reset_i & ~post_rst_q;
    tx_push  = bus_wr && (addr_i == 2'd0) && !tx_full;
    tx_pop   = pulse_ok && (state_q == IDLE) && !tx_empty && !uart_busy_i;
    rx_take  = pulse_ok && uart_valid_i && !rx_guard_q;
    rx_pop   = bus_rd && (addr_i == 2'd0) && !rx_empty;
    rx_push  = rx_take && (!rx_full || rx_pop);
    uart_wr_o      = tx_pop;
    uart_tx_data_o = tx_pop ? tx_mem_q[tx_rp_q] : 8'h00;
    uart_rd_o      = rx_take;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (tx_pop) state_d = GUARD;
      GUARD: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_wp_d    = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d    = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
    rx_wp_d    = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d    = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
    tx_cnt_d   = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d   = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    rx_guard_d = rx_take;
    post_rst_d = 1'b0;

    // Set after clear so a same-cycle overflow beats the W1C.
    tx_ovr_d = tx_ovr_q;
    rx_ovr_d = rx_ovr_q;
    if (bus_wr && (addr_i == 2'd1) && wdata_i[5]) tx_ovr_d = 1'b0;
    if (bus_wr && (addr_i == 2'd1) && wdata_i[4]) rx_ovr_d = 1'b0;
    if (bus_wr && (addr_i == 2'd0) && tx_full) tx_ovr_d = 1'b1;
    if (rx_take && rx_full && !rx_pop) rx_ovr_d = 1'b1;

    ctrl_d = ctrl_q;
    if (bus_wr && (addr_i == 2'd2)) ctrl_d = wdata_i[1:0];

    status = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 2'b00,
              tx_ovr_q, rx_ovr_q, rx_full, rx_empty, tx_empty, tx_full};

    rdata_d = rdata_q;
    if (bus_rd) begin
      case (addr_i)
        2'd0:    rdata_d = rx_empty ? 32'h0 : {23'h0, 1'b1, rx_mem_q[rx_rp_q]};
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = {30'h0, ctrl_q};
        default: rdata_d = 32'h0;
      endcase
    end

    irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      rx_guard_q <= 1'b0;
      post_rst_q <= 1'b1;
      tx_ovr_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      ctrl_q     <= 2'b00;
      rdata_q    <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_guard_q <= rx_guard_d;
      post_rst_q <= post_rst_d;
      tx_ovr_q   <= tx_ovr_d;
      rx_ovr_q   <= rx_ovr_d;
      ctrl_q     <= ctrl_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= wdata_i[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= uart_rx_data_i;
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: a small UART model drives busy/valid, and queue-based
// models of both FIFOs and the sticky flags predict every register read.
module tb_uart_fifo_ctrl;
  localparam int DEPTH = 16;
  localparam int BUSY_LEN = 20;

  logic        clk = 1'b0;
  logic        reset_i, sel_i, we_i, irq_o, uart_wr_o, uart_rd_o, uart_valid_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i, rdata_o;
  logic [7:0]  uart_tx_data_o, uart_rx_data_i;
  logic        uart_busy_i;

  logic busy_force = 1'b0;
  int   busy_cnt = 0;
  bit   arm = 0, wr_seen = 0;
  assign uart_busy_i = busy_force | (busy_cnt != 0);

  int         n_checks = 0, n_fail = 0;
  logic [7:0] sent_q[$];
  int         wr_viol = 0, rd_pulses = 0, cyc = 0, last_wr_cyc = -1000, min_gap = 1000000;

  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  bit         tx_ovr_m = 0, rx_ovr_m = 0;

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_i(reset_i), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .irq_o(irq_o), .uart_wr_o(uart_wr_o),
    .uart_tx_data_o(uart_tx_data_o), .uart_busy_i(uart_busy_i), .uart_rd_o(uart_rd_o),
    .uart_rx_data_i(uart_rx_data_i), .uart_valid_i(uart_valid_i)
  );

  // Mid-cycle monitor of the UART-side handshakes.
  always begin
    @(negedge clk);
    cyc++;
    if (uart_wr_o === 1'b1) begin
      sent_q.push_back(uart_tx_data_o);
      if (uart_busy_i) wr_viol++;
      if (cyc - last_wr_cyc < min_gap) min_gap = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
      wr_seen = 1;
    end
    if (uart_rd_o === 1'b1) rd_pulses++;
  end

  // UART busy: rises one cycle after the wr-sampling edge and lasts BUSY_LEN cycles.
  always begin
    @(posedge clk);
    #1;
    if (busy_cnt != 0) busy_cnt--;
    if (arm) begin busy_cnt = BUSY_LEN; arm = 0; end
    if (wr_seen) begin arm = 1; wr_seen = 0; end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_status();
    int txc, rxc;
    logic [31:0] s;
    txc = tx_m.size() - sent_q.size();
    rxc = rx_m.size();
    s = 32'h0;
    s[0] = (txc == DEPTH);
    s[1] = (txc == 0);
    s[2] = (rxc == 0);
    s[3] = (rxc == DEPTH);
    s[4] = rx_ovr_m;
    s[5] = tx_ovr_m;
    s[15:8] = 8'(rxc);
    s[23:16] = 8'(txc);
    return s;
  endfunction

  function automatic logic [31:0] model_data_read();
    if (rx_m.size() == 0) return 32'h0;
    return {23'h0, 1'b1, rx_m.pop_front()};
  endfunction

  task automatic model_tx_write(input logic [7:0] b);
    if (tx_m.size() - sent_q.size() == DEPTH) tx_ovr_m = 1;
    else tx_m.push_back(b);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel_i = 1; we_i = 1; addr_i = a; wdata_i = d;
    @(posedge clk); #1;
    sel_i = 0; we_i = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel_i = 1; we_i = 0; addr_i = a;
    @(posedge clk); #1;
    sel_i = 0;
    d = rdata_o;
  endtask

  // Presents a byte until rd, then holds the stale valid one more cycle.
  task automatic rx_deliver(input logic [7:0] b, output bit got);
    uart_valid_i = 1; uart_rx_data_i = b; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (uart_rd_o === 1'b1) got = 1;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    uart_valid_i = 0;
    if (got) begin
      if (rx_m.size() == DEPTH) rx_ovr_m = 1;
      else rx_m.push_back(b);
    end
  endtask

  task automatic wait_tx_drain(input string name);
    int k;
    for (k = 0; k < 3000 && (sent_q.size() < tx_m.size() || uart_busy_i); k++) @(posedge clk);
    #1;
    n_checks++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL %s_timeout: sent %0d of %0d bytes", name, sent_q.size(), tx_m.size());
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_i = 1; uart_valid_i = 1; uart_rx_data_i = 8'h77;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (uart_rd_o !== 1'b0 || uart_wr_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_cycle_pulse: rd=%b wr=%b, required 0 0", uart_rd_o, uart_wr_o);
    end
    @(posedge clk); #1;
    reset_i = 0;
    @(negedge clk);
    n_checks++;
    if (uart_rd_o !== 1'b0 || uart_wr_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_pulse: rd=%b wr=%b, required 0 0", uart_rd_o, uart_wr_o);
    end
    n_checks++;
    if (rdata_o !== 32'h0 || irq_o !== 1'b0 || uart_tx_data_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: rdata=%h irq=%b txd=%h, required 0 0 0", rdata_o, irq_o, uart_tx_data_o);
    end
    @(posedge clk); #1;
    uart_valid_i = 0;
    bus_read(2'd1, r);
    n_checks++;
    if (r !== 32'h0000_0006) begin
      n_fail++; $display("FAIL reset_status: got %h, required 00000006", r);
    end
    bus_read(2'd2, r);
    n_checks++;
    if (r !== 32'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h, required 0", r);
    end
  endtask

  task automatic test_tx_drain();
    logic [31:0] r;
    logic [7:0] b;
    int n;
    busy_force = 0; min_gap = 1000000; wr_viol = 0;
    model_tx_write(8'h41);
    bus_write(2'd0, 32'h41);
    @(negedge clk);
    n_checks++;
    if (uart_wr_o !== 1'b1 || uart_tx_data_o !== 8'h41) begin
      n_fail++; $display("FAIL tx_latency: wr=%b data=%h, required 1 41", uart_wr_o, uart_tx_data_o);
    end
    @(posedge clk); #1;
    model_tx_write(8'h42);
    bus_write(2'd0, 32'h42);
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      model_tx_write(b);
      bus_write(2'd0, {24'h0, b});
    end
    wait_tx_drain("tx_drain");
    n_checks++;
    if (sent_q.size() !== tx_m.size()) begin
      n_fail++; $display("FAIL tx_drain_count: sent %0d, required %0d", sent_q.size(), tx_m.size());
    end
    for (int i = 0; i < tx_m.size() && i < sent_q.size(); i++) begin
      n_checks++;
      if (sent_q[i] !== tx_m[i]) begin
        n_fail++; $display("FAIL tx_drain_byte%0d: got %h, required %h", i, sent_q[i], tx_m[i]);
      end
    end
    n_checks++;
    if (wr_viol != 0 || min_gap != BUSY_LEN + 2) begin
      n_fail++; $display("FAIL tx_spacing: wr_while_busy=%0d min_gap=%0d, required 0 %0d", wr_viol, min_gap, BUSY_LEN + 2);
    end
    bus_read(2'd1, r);
    n_checks++;
    if (r !== model_status()) begin
      n_fail++; $display("FAIL tx_drain_status: got %h, required %h", r, model_status());
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] r;
    sent_q.delete(); tx_m.delete(); wr_viol = 0;
    busy_force = 1;
    for (int i = 0; i <= DEPTH; i++) begin
      model_tx_write(8'(i));
      bus_write(2'd0, i);
    end
    bus_read(2'd1, r);
    n_checks++;
    if (r !== model_status()) begin
      n_fail++; $display("FAIL tx_ovr_status: got %h, required %h", r, model_status());
    end
    bus_write(2'd1, 32'h20);
    tx_ovr_m = 0;
    bus_read(2'd1, r);
    n_checks++;
    if (r !== model_status()) begin
      n_fail++; $display("FAIL tx_ovr_w1c: got %h, required %h", r, model_status());
    end
    busy_force = 0;
    wait_tx_drain("tx_ovr_drain");
    n_checks++;
    if (sent_q.size() !== DEPTH || wr_viol != 0) begin
      n_fail++; $display("FAIL tx_ovr_sent: count %0d viol %0d, required %0d 0", sent_q.size(), wr_viol, DEPTH);
    end
    for (int i = 0; i < sent_q.size() && i < tx_m.size(); i++) begin
      n_checks++;
      if (sent_q[i] !== tx_m[i]) begin
        n_fail++; $display("FAIL tx_ovr_byte%0d: got %h, required %h", i, sent_q[i], tx_m[i]);
      end
    end
  endtask

  task automatic test_rx_single();
    logic [31:0] r, e;
    bit got;
    int rp0;
    rp0 = rd_pulses;
    rx_deliver(8'h55, got);
    @(posedge clk); #1;
    n_checks++;
    if (!got || rd_pulses - rp0 != 1) begin
      n_fail++; $display("FAIL rx_single_rd: pulses %0d, required 1", rd_pulses - rp0);
    end
    e = model_data_read();
    bus_read(2'd0, r);
    n_checks++;
    if (r !== e) begin
      n_fail++; $display("FAIL rx_single_data: got %h, required %h", r, e);
    end
    e = model_data_read();
    bus_read(2'd0, r);
    n_checks++;
    if (r !== e) begin
      n_fail++; $display("FAIL rx_single_empty: got %h, required %h", r, e);
    end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] r, e;
    bit got;
    int ngot = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      rx_deliver(8'hA0 + 8'(i), got);
      if (got) ngot++;
    end
    n_checks++;
    if (ngot != DEPTH + 1) begin
      n_fail++; $display("FAIL rx_ovr_rd: got %0d rd pulses, required %0d", ngot, DEPTH + 1);
    end
    bus_read(2'd1, r);
    n_checks++;
    if (r !== model_status()) begin
      n_fail++; $display("FAIL rx_ovr_status: got %h, required %h", r, model_status());
    end
    for (int i = 0; i < DEPTH; i++) begin
      e = model_data_read();
      bus_read(2'd0, r);
      n_checks++;
      if (r !== e) begin
        n_fail++; $display("FAIL rx_ovr_data%0d: got %h, required %h", i, r, e);
      end
    end
    bus_write(2'd1, 32'h10);
    rx_ovr_m = 0;
    bus_read(2'd1, r);
    n_checks++;
    if (r !== model_status()) begin
      n_fail++; $display("FAIL rx_ovr_w1c: got %h, required %h", r, model_status());
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] r, e;
    logic [7:0] b;
    bit got;
    for (int i = 0; i < DEPTH; i++) rx_deliver(8'($urandom), got);
    b = 8'($urandom);
    uart_valid_i = 1; uart_rx_data_i = b;
    sel_i = 1; we_i = 0; addr_i = 2'd0;
    @(negedge clk);
    n_checks++;
    if (uart_rd_o !== 1'b1) begin
      n_fail++; $display("FAIL full_pushpop_rd: rd=%b, required 1", uart_rd_o);
    end
    @(posedge clk); #1;
    sel_i = 0;
    e = model_data_read();
    rx_m.push_back(b);
    n_checks++;
    if (rdata_o !== e) begin
      n_fail++; $display("FAIL full_pushpop_data: got %h, required %h", rdata_o, e);
    end
    @(posedge clk); #1;
    uart_valid_i = 0;
    bus_read(2'd1, r);
    n_checks++;
    if (r !== model_status()) begin
      n_fail++; $display("FAIL full_pushpop_status: got %h, required %h", r, model_status());
    end
    for (int i = 0; i < DEPTH; i++) begin
      e = model_data_read();
      bus_read(2'd0, r);
      n_checks++;
      if (r !== e) begin
        n_fail++; $display("FAIL full_pushpop_drain%0d: got %h, required %h", i, r, e);
      end
    end
  endtask

  task automatic test_rx_random();
    logic [31:0] r, e;
    bit got;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        rx_deliver(8'($urandom), got);
      end else begin
        e = model_data_read();
        bus_read(2'd0, r);
        n_checks++;
        if (r !== e) begin
          n_fail++; $display("FAIL rx_random_read%0d: got %h, required %h", i, r, e);
        end
      end
    end
    bus_read(2'd1, r);
    n_checks++;
    if (r !== model_status()) begin
      n_fail++; $display("FAIL rx_random_status: got %h, required %h", r, model_status());
    end
    while (rx_m.size() != 0) begin
      e = model_data_read();
      bus_read(2'd0, r);
      n_checks++;
      if (r !== e) begin
        n_fail++; $display("FAIL rx_random_drain: got %h, required %h", r, e);
      end
    end
    bus_write(2'd1, 32'h30);
    rx_ovr_m = 0;
  endtask

  task automatic test_irq();
    logic [31:0] r, e;
    bus_write(2'd2, 32'h1);
    uart_valid_i = 1; uart_rx_data_i = 8'h3C;
    @(negedge clk);
    n_checks++;
    if (uart_rd_o !== 1'b1) begin
      n_fail++; $display("FAIL irq_rx_rd: rd=%b, required 1", uart_rd_o);
    end
    rx_m.push_back(8'h3C);
    @(posedge clk); #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_rx_early: irq=%b, required 0", irq_o);
    end
    @(posedge clk); #1;
    uart_valid_i = 0;
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++; $display("FAIL irq_rx_set: irq=%b, required 1", irq_o);
    end
    bus_read(2'd2, r);
    n_checks++;
    if (r !== 32'h1) begin
      n_fail++; $display("FAIL irq_ctrl_read: got %h, required 00000001", r);
    end
    e = model_data_read();
    bus_read(2'd0, r);
    n_checks++;
    if (r !== e) begin
      n_fail++; $display("FAIL irq_rx_data: got %h, required %h", r, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_rx_clear: irq=%b, required 0", irq_o);
    end
    bus_write(2'd2, 32'h2);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_tx_early: irq=%b, required 0", irq_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++; $display("FAIL irq_tx_set: irq=%b, required 1", irq_o);
    end
    bus_write(2'd2, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_disable: irq=%b, required 0", irq_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bit got;
    int sn, rp;
    busy_force = 1;
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h60 + i);
    rx_deliver(8'h11, got);
    rx_deliver(8'h22, got);
    sn = sent_q.size(); rp = rd_pulses;
    reset_i = 1; busy_force = 0; uart_valid_i = 1; uart_rx_data_i = 8'h99;
    @(negedge clk);
    n_checks++;
    if (uart_wr_o !== 1'b0 || uart_rd_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_cycle: wr=%b rd=%b, required 0 0", uart_wr_o, uart_rd_o);
    end
    @(posedge clk); #1;
    reset_i = 0;
    @(negedge clk);
    n_checks++;
    if (uart_wr_o !== 1'b0 || uart_rd_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: wr=%b rd=%b, required 0 0", uart_wr_o, uart_rd_o);
    end
    @(posedge clk); #1;
    uart_valid_i = 0;
    tx_m.delete(); sent_q.delete(); rx_m.delete(); tx_ovr_m = 0; rx_ovr_m = 0;
    bus_read(2'd1, r);
    n_checks++;
    if (r !== model_status()) begin
      n_fail++; $display("FAIL midrst_status: got %h, required %h", r, model_status());
    end
    n_checks++;
    if (sent_q.size() != 0 || rd_pulses != rp) begin
      n_fail++; $display("FAIL midrst_pulses: wr %0d rd %0d after reset, required 0 0 (sent before %0d)", sent_q.size(), rd_pulses - rp, sn);
    end
  endtask

  initial begin
    reset_i = 1; sel_i = 0; we_i = 0; addr_i = 2'd0; wdata_i = 32'h0;
    uart_valid_i = 0; uart_rx_data_i = 8'h00;
    test_reset();
    test_tx_drain();
    test_tx_overflow();
    test_rx_single();
    test_rx_overflow();
    test_push_pop_full();
    test_rx_random();
    test_irq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
